// File: rtl/serial_frame_rx.sv
// Serial frame receiver: hunts for a sync pattern, then deserializes FRAME_WORDS
// MSB-first words into a small output FIFO. Define SERIAL_FRAME_RX_PARITY_EN for per-word even parity.
`timescale 1ns/1ps

module serial_frame_rx #(
  parameter int                DATA_W       = 8,
  parameter int                SYNC_W       = 8,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = 8'hA5,
  parameter int                FRAME_WORDS  = 4,
  parameter int                FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_bit,
  input  logic              bit_en,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              locked,
  output logic              frame_done,
  output logic              overflow,
  output logic              parity_err
);

`ifdef SERIAL_FRAME_RX_PARITY_EN
  localparam int WORD_BITS = DATA_W + 1;
`else
  localparam int WORD_BITS = DATA_W;
`endif
  localparam int BCNT_W = $clog2(WORD_BITS + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [BCNT_W-1:0] LAST_BIT   = BCNT_W'(WORD_BITS - 1);
  localparam logic [BCNT_W-1:0] BCNT_ONE   = BCNT_W'(1);
  localparam logic [7:0]        FRAME_LAST = 8'(FRAME_WORDS - 1);
  localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    ST_HUNT = 1'b0,
    ST_DATA = 1'b1
  } state_t;

`ifdef SERIAL_FRAME_RX_PARITY_EN
  function automatic logic parity_ok(input logic [DATA_W-1:0] data, input logic par);
    parity_ok = ~(^{data, par});
  endfunction
`endif

  state_t              state_q, state_d;
  logic [SYNC_W-1:0]   hist_q, hist_d;
  logic [BCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]          word_cnt_q, word_cnt_d;
  logic [DATA_W-1:0]   word_q, word_d;

  logic                word_done_s;
  logic                word_ok_s;
  logic                push_s;
  logic                pop_s;
  logic                full_s;
  logic                wr_en_s;
  logic                drop_s;
  logic                last_word_s;
  logic [DATA_W-1:0]   done_word_s;
  logic [CNT_W-1:0]    count_d;

  logic                locked_q;
  logic                frame_done_q;
  logic                overflow_q;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q;

  // State register together with the shift/count datapath it sequences.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_HUNT;
      hist_q     <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      word_q     <= '0;
    end else begin
      state_q    <= state_d;
      hist_q     <= hist_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      word_q     <= word_d;
    end
  end

  // Next-state logic; nothing advances on cycles without bit_en.
  always_comb begin
    state_d    = state_q;
    hist_d     = hist_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    word_d     = word_q;
    if (bit_en) begin
      case (state_q)
        ST_HUNT: begin
          hist_d = {hist_q[SYNC_W-2:0], in_bit};
          if (hist_d == SYNC_PATTERN) begin
            state_d    = ST_DATA;
            bit_cnt_d  = '0;
            word_cnt_d = '0;
            word_d     = '0;
          end else begin
            state_d = ST_HUNT;
          end
        end
        ST_DATA: begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
          // The trailing parity bit is not shifted into the data word.
          if (bit_cnt_q != LAST_BIT) begin
            word_d = {word_q[DATA_W-2:0], in_bit};
          end else begin
            word_d = word_q;
          end
`else
          word_d = {word_q[DATA_W-2:0], in_bit};
`endif
          if (word_done_s) begin
            bit_cnt_d = '0;
            if (last_word_s) begin
              state_d    = ST_HUNT;
              hist_d     = '0;
              word_cnt_d = '0;
            end else begin
              word_cnt_d = word_cnt_q + 8'd1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BCNT_ONE;
          end
        end
        default: begin
          state_d = ST_HUNT;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Word completion, FIFO push/pop arbitration and next-cycle output values.
  always_comb begin
    word_done_s = 1'b0;
    if (bit_en && (state_q == ST_DATA) && (bit_cnt_q == LAST_BIT)) begin
      word_done_s = 1'b1;
    end else begin
      word_done_s = 1'b0;
    end
`ifdef SERIAL_FRAME_RX_PARITY_EN
    done_word_s = word_q;
    word_ok_s   = parity_ok(word_q, in_bit);
`else
    done_word_s = {word_q[DATA_W-2:0], in_bit};
    word_ok_s   = 1'b1;
`endif
    push_s      = word_done_s && word_ok_s;
    last_word_s = word_done_s && (word_cnt_q == FRAME_LAST);
    pop_s       = (count_q != '0) && out_ready;
    full_s      = (count_q == FULL_CNT);
    // A full FIFO still accepts a word when the head leaves on the same edge.
    wr_en_s     = push_s && (!full_s || pop_s);
    drop_s      = push_s && full_s && !pop_s;
    case ({wr_en_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Status output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked_q     <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      locked_q     <= (state_d == ST_DATA);
      frame_done_q <= last_word_s;
      overflow_q   <= overflow_q | drop_s;
    end
  end

  // Output FIFO storage and pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en_s) begin
        mem_q[wr_ptr_q] <= done_word_s;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      count_q <= count_d;
    end
  end

`ifdef SERIAL_FRAME_RX_PARITY_EN
  logic parity_err_q;

  // Parity mismatch pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= word_done_s && !word_ok_s;
    end
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign out_data   = mem_q[rd_ptr_q];
  assign out_valid  = (count_q != '0);
  assign locked     = locked_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx: directed scenarios plus randomized
// streams, compared every cycle against a queue-based behavioural model.
`timescale 1ns/1ps

module tb_serial_frame_rx;

  localparam int DEPTH = 4;
  localparam int FRAME = 4;
  localparam int SYNC  = 8'hA5;
`ifdef SERIAL_FRAME_RX_PARITY_EN
  localparam int WB = 9;
`else
  localparam int WB = 8;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_bit = 1'b0;
  logic       bit_en = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       locked;
  logic       frame_done;
  logic       overflow;
  logic       parity_err;

  serial_frame_rx dut (
    .clk        (clk),
    .rst        (rst),
    .in_bit     (in_bit),
    .bit_en     (bit_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .locked     (locked),
    .frame_done (frame_done),
    .overflow   (overflow),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errs   = 0;

  // Behavioural model: spec-level state, FIFO kept as a queue.
  bit         m_hunt = 1'b1;
  int         m_hist = 0;
  int         m_nb   = 0;
  int         m_cur  = 0;
  int         m_wc   = 0;
  logic [7:0] m_q[$];
  bit         exp_locked = 1'b0;
  bit         exp_fd = 1'b0;
  bit         exp_perr = 1'b0;
  bit         exp_ovf = 1'b0;
  bit         m_pop, m_have, m_good;
  logic [7:0] m_w;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hunt = 1'b1; m_hist = 0; m_nb = 0; m_cur = 0; m_wc = 0;
      m_q.delete();
      exp_locked = 1'b0; exp_fd = 1'b0; exp_perr = 1'b0; exp_ovf = 1'b0;
    end else begin
      exp_fd = 1'b0; exp_perr = 1'b0; m_have = 1'b0; m_w = 8'h00;
      m_pop = (m_q.size() > 0) && out_ready;
      if (bit_en) begin
        if (m_hunt) begin
          m_hist = (m_hist * 2 + int'(in_bit)) % 256;
          if (m_hist == SYNC) begin
            m_hunt = 1'b0; m_nb = 0; m_cur = 0; m_wc = 0;
          end
        end else begin
          m_cur = m_cur * 2 + int'(in_bit);
          m_nb++;
          if (m_nb == WB) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
            m_good = ($countones(m_cur) % 2) == 0;
            m_w    = 8'(m_cur / 2);
`else
            m_good = 1'b1;
            m_w    = 8'(m_cur);
`endif
            m_nb = 0; m_cur = 0; m_wc++;
            if (m_good) m_have = 1'b1;
            else exp_perr = 1'b1;
            if (m_wc == FRAME) begin
              exp_fd = 1'b1; m_hunt = 1'b1; m_hist = 0;
            end
          end
        end
      end
      if (m_pop) void'(m_q.pop_front());
      if (m_have) begin
        if (m_q.size() < DEPTH) m_q.push_back(m_w);
        else exp_ovf = 1'b1;
      end
      exp_locked = !m_hunt;
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("locked", int'(locked), int'(exp_locked));
      chk("frame_done", int'(frame_done), int'(exp_fd));
      chk("overflow", int'(overflow), int'(exp_ovf));
      chk("parity_err", int'(parity_err), int'(exp_perr));
      chk("out_valid", int'(out_valid), int'(m_q.size() != 0));
      if (m_q.size() != 0) chk("out_data", int'(out_data), int'(m_q[0]));
    end
  end

  // Record what the DUT actually hands over, for the literal expectations.
  logic [7:0] got[$];
  logic [7:0] exp_w[$];
  int fd_cnt = 0;
  int pe_cnt = 0;
  always @(posedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) got.push_back(out_data);
      if (frame_done) fd_cnt++;
      if (parity_err) pe_cnt++;
    end
  end

  bit rnd  = 1'b0;
  bit gaps = 1'b0;
  bit rdy_v = 1'b1;

  task automatic drive(input logic b, input logic en);
    @(negedge clk);
    #1;
    in_bit = b;
    bit_en = en;
    out_ready = rnd ? ($urandom_range(0, 99) < 60) : rdy_v;
  endtask

  task automatic send_bit(input logic b);
    if (rnd) repeat ($urandom_range(0, 2)) drive(1'($urandom_range(0, 1)), 1'b0);
    drive(b, 1'b1);
    if (gaps) drive(~b, 1'b0);
  endtask

  task automatic send_word_p(input logic [7:0] v, input logic p, input bit pop_last);
    logic bits[$];
    for (int i = 7; i >= 0; i--) bits.push_back(v[i]);
`ifdef SERIAL_FRAME_RX_PARITY_EN
    bits.push_back(p);
`endif
    for (int i = 0; i < bits.size(); i++) begin
      if (pop_last && i == bits.size() - 1) rdy_v = 1'b1;
      send_bit(bits[i]);
    end
    if (pop_last) rdy_v = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] v);
    send_word_p(v, ^v, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0);
  endtask

  task automatic expect_words(input string tag);
    chk({tag, "_count"}, got.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < got.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), int'(got[i]), int'(exp_w[i]));
    got.delete();
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk({tag, "_valid"}, int'(out_valid), 0);
    chk({tag, "_data"}, int'(out_data), 0);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_fdone"}, int'(frame_done), 0);
    chk({tag, "_ovf"}, int'(overflow), 0);
    chk({tag, "_perr"}, int'(parity_err), 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    got.delete();
    fd_cnt = 0;
    pe_cnt = 0;
  endtask

  logic [11:0] pat;

  initial begin
    do_reset("rst0");

    // Basic frame.
    rdy_v = 1'b1;
    send_word(8'hA5); send_word(8'h3C); send_word(8'h81); send_word(8'hFF); send_word(8'h00);
    idle(4);
    exp_w = '{8'h3C, 8'h81, 8'hFF, 8'h00};
    expect_words("s1");
    chk("s1_fdone_cnt", fd_cnt, 1); fd_cnt = 0;

    // Sync embedded after a partial match.
    pat = 12'b1010_1010_0101;
    for (int i = 11; i >= 0; i--) send_bit(pat[i]);
    send_word(8'h3C); send_word(8'h81); send_word(8'hFF); send_word(8'h00);
    idle(4);
    exp_w = '{8'h3C, 8'h81, 8'hFF, 8'h00};
    expect_words("s2");
    chk("s2_fdone_cnt", fd_cnt, 1); fd_cnt = 0;

    // Backpressure until the FIFO overflows.
    rdy_v = 1'b0;
    send_word(8'hA5); send_word(8'h11); send_word(8'h22); send_word(8'h33); send_word(8'h44);
    send_word(8'hA5); send_word(8'h55); send_word(8'h66); send_word(8'h77); send_word(8'h88);
    idle(2);
    chk("s3_ovf_set", int'(overflow), 1);
    rdy_v = 1'b1;
    idle(8);
    chk("s3_ovf_sticky", int'(overflow), 1);
    exp_w = '{8'h11, 8'h22, 8'h33, 8'h44};
    expect_words("s3");

    // Full FIFO with a pop on the same edge as the push.
    do_reset("rst1");
    rdy_v = 1'b0;
    send_word(8'hA5); send_word(8'h11); send_word(8'h22); send_word(8'h33); send_word(8'h44);
    send_word(8'hA5);
    send_word_p(8'h55, ^(8'h55), 1'b1);
    idle(1);
    chk("s3b_no_ovf", int'(overflow), 0);
    rdy_v = 1'b1;
    send_word(8'h66); send_word(8'h77); send_word(8'h88);
    idle(8);
    chk("s3b_no_ovf_end", int'(overflow), 0);
    exp_w = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    expect_words("s3b");
    fd_cnt = 0;

    // bit_en gaps stretch timing without changing content.
    gaps = 1'b1;
    send_word(8'hA5); send_word(8'h3C); send_word(8'h81); send_word(8'hFF); send_word(8'h00);
    gaps = 1'b0;
    idle(4);
    exp_w = '{8'h3C, 8'h81, 8'hFF, 8'h00};
    expect_words("s4");
    chk("s4_fdone_cnt", fd_cnt, 1);

    // Reset mid-way through the second word; resync is required afterwards.
    rdy_v = 1'b0;
    send_word(8'hA5); send_word(8'h3C);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    do_reset("rst2");
    rdy_v = 1'b1;
    send_word(8'h3C); send_word(8'h81); send_word(8'hFF); send_word(8'h00);
    idle(4);
    chk("s5_no_output", got.size(), 0);
    chk("s5_unlocked", int'(locked), 0);
    chk("s5_no_fdone", fd_cnt, 0);

`ifdef SERIAL_FRAME_RX_PARITY_EN
    // Bad parity on the second data word.
    send_word(8'hA5);
    send_word_p(8'h3C, 1'b0, 1'b0);
    send_word_p(8'h81, 1'b1, 1'b0);
    send_word(8'hFF); send_word(8'h00);
    idle(4);
    exp_w = '{8'h3C, 8'hFF, 8'h00};
    expect_words("par");
    chk("par_err_cnt", pe_cnt, 1);
    chk("par_fdone_cnt", fd_cnt, 1);
`endif

    // Randomized streams with random gaps and backpressure.
    rnd = 1'b1;
    for (int it = 0; it < 60; it++) begin
      if (it == 30) do_reset("rst3");
      if ($urandom_range(0, 2) == 0) send_word(8'hA5);
      else if ($urandom_range(0, 5) == 0) send_word_p(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
      else send_word(8'($urandom_range(0, 255)));
    end
    rnd = 1'b0;
    rdy_v = 1'b1;
    idle(10);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
